// File: rtl/sb_pkg.sv
// Shared definitions for the single-master system-bus interconnect:
// FSM state encoding, default address map and the error read-data pattern.
package sb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } sb_state_e;

    localparam int          DEF_N_SLAVES   = 9;
    localparam int          MAX_SLAVES     = 16;
    localparam logic [31:0] DEF_BASE_START = 32'h0200_0000;
    localparam logic [31:0] DEF_SLAVE_MASK = 32'hFF00_0000;
    localparam logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF;

    // Slave k owns the 16 MiB window starting at 0x0200_0000 + k*16 MiB.
    function automatic logic [MAX_SLAVES*32-1:0] default_base_map();
        logic [MAX_SLAVES*32-1:0] map;
        map = '0;
        for (int k = 0; k < MAX_SLAVES; k++) begin
            map[k*32 +: 32] = DEF_BASE_START + (32'(k) << 24);
        end
        return map;
    endfunction

    localparam logic [MAX_SLAVES*32-1:0] DEF_SLAVE_BASE = default_base_map();

endpackage

// File: rtl/sb_addr_decoder.sv
// Address decoder: base/mask match per slave, lowest index wins on overlap.
// Latency: combinational. Backpressure: none, pure function of the address.
module sb_addr_decoder #(
    parameter int N_SLAVES = 9,
    parameter int ADDR_W   = 32,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [N_SLAVES-1:0] sel_o,
    output logic                vld_o
);

    logic [N_SLAVES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            hit[k] = ((addr_i & SLAVE_MASK[k]) == SLAVE_BASE[k]);
        end
    end

    // Isolate the lowest set bit so overlapping windows resolve to one slave.
    assign sel_o = hit & (~hit + N_SLAVES'(1));
    assign vld_o = |hit;

endmodule

// File: rtl/sb_interconnect.sv
// Single-master to N-slave bus interconnect; SB_TIMEOUT_EN adds an ACCESS watchdog.
// Latency: 3 cycles minimum on a hit, 2 on a decode miss; one-cycle m_ready_o pulse.
// Backpressure: master holds m_req_i until m_ready_o; slave stalls by withholding s_ready_i.
module sb_interconnect #(
    parameter int N_SLAVES       = sb_pkg::DEF_N_SLAVES,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE =
        sb_pkg::DEF_SLAVE_BASE[N_SLAVES*ADDR_W-1:0],
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK =
        {N_SLAVES{sb_pkg::DEF_SLAVE_MASK}},
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA = sb_pkg::ERR_RDATA
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             m_req_i,
    input  logic                             m_we_i,
    input  logic [DATA_W/8-1:0]              m_be_i,
    input  logic [ADDR_W-1:0]                m_addr_i,
    input  logic [DATA_W-1:0]                m_wd_i,
    output logic [DATA_W-1:0]                m_rd_o,
    output logic                             m_ready_o,
    output logic                             m_err_o,
    output logic [N_SLAVES-1:0]              s_req_o,
    output logic                             s_we_o,
    output logic [DATA_W/8-1:0]              s_be_o,
    output logic [ADDR_W-1:0]                s_addr_o,
    output logic [DATA_W-1:0]                s_wd_o,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]  s_rd_i,
    input  logic [N_SLAVES-1:0]              s_ready_i
);

    import sb_pkg::*;

    localparam int BE_W = DATA_W / 8;

    sb_state_e           state_q, state_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;

    logic [N_SLAVES-1:0] dec_sel;
    logic                dec_vld;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rd;

`ifdef SB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    sb_addr_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr_i (m_addr_i),
        .sel_o  (dec_sel),
        .vld_o  (dec_vld)
    );

    // sel_q is one-hot, so an OR-mux picks the selected slave's data.
    always_comb begin
        sel_rd = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q[k]) begin
                sel_rd = sel_rd | s_rd_i[k];
            end
        end
    end

    assign sel_ready = |(s_ready_i & sel_q);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        err_d   = err_q;
`ifdef SB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    we_d   = m_we_i;
                    be_d   = m_be_i;
                    addr_d = m_addr_i;
                    wd_d   = m_wd_i;
                    sel_d  = dec_sel;
`ifdef SB_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                    if (dec_vld) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = RESP;
                        rd_d    = ERR_RDATA;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d = RESP;
                    rd_d    = we_q ? '0 : sel_rd;
                    err_d   = 1'b0;
                end
`ifdef SB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    rd_d    = ERR_RDATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef SB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef SB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_ready_o = (state_q == RESP);
    assign m_rd_o    = rd_q;
    assign m_err_o   = err_q;
    assign s_req_o   = (state_q == ACCESS) ? sel_q : '0;
    assign s_we_o    = we_q;
    assign s_be_o    = be_q;
    assign s_addr_o  = addr_q;
    assign s_wd_o    = wd_q;

endmodule

// File: tb/tb_sb_interconnect.sv
// Directed self-checking bench for sb_interconnect; slave 5's window is widened
// to overlap slave 2. Timeout vectors run only when SB_TIMEOUT_EN is defined.
module tb_sb_interconnect;

    localparam int N  = 9;
    localparam int DW = 32;
    localparam int AW = 32;

    function automatic logic [N-1:0][AW-1:0] tb_base();
        logic [N-1:0][AW-1:0] b;
        for (int k = 0; k < N; k++) b[k] = 32'h0200_0000 + (32'(k) << 24);
        b[5] = 32'h0400_0000;
        return b;
    endfunction

    function automatic logic [N-1:0][AW-1:0] tb_mask();
        logic [N-1:0][AW-1:0] m;
        for (int k = 0; k < N; k++) m[k] = 32'hFF00_0000;
        m[5] = 32'hFE00_0000;
        return m;
    endfunction

    localparam logic [N-1:0][AW-1:0] TB_BASE = tb_base();
    localparam logic [N-1:0][AW-1:0] TB_MASK = tb_mask();

    logic                   clk_i;
    logic                   rst_i;
    logic                   m_req_i;
    logic                   m_we_i;
    logic [DW/8-1:0]        m_be_i;
    logic [AW-1:0]          m_addr_i;
    logic [DW-1:0]          m_wd_i;
    logic [DW-1:0]          m_rd_o;
    logic                   m_ready_o;
    logic                   m_err_o;
    logic [N-1:0]           s_req_o;
    logic                   s_we_o;
    logic [DW/8-1:0]        s_be_o;
    logic [AW-1:0]          s_addr_o;
    logic [DW-1:0]          s_wd_o;
    logic [N-1:0][DW-1:0]   s_rd_i;
    logic [N-1:0]           s_ready_i;

    int checks   = 0;
    int failures = 0;

    sb_interconnect #(
        .N_SLAVES       (N),
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .SLAVE_BASE     (TB_BASE),
        .SLAVE_MASK     (TB_MASK),
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_be_i    (m_be_i),
        .m_addr_i  (m_addr_i),
        .m_wd_i    (m_wd_i),
        .m_rd_o    (m_rd_o),
        .m_ready_o (m_ready_o),
        .m_err_o   (m_err_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_be_o    (s_be_o),
        .s_addr_o  (s_addr_o),
        .s_wd_o    (s_wd_o),
        .s_rd_i    (s_rd_i),
        .s_ready_i (s_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one master transaction; cycle 1 is the request cycle.
    // ready_at = ACCESS cycle (1-based) in which slave slv asserts ready; 0 = never.
    task automatic txn(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int slv, input int ready_at, input logic [N-1:0] noise,
                       input logic [N-1:0] exp_req, input int exp_lat, input int exp_acc,
                       input logic [31:0] exp_rd, input logic exp_err);
        int   cyc;
        int   acc;
        int   bad_req;
        logic done;
        logic [31:0] rd_seen;
        logic        err_seen;
        cyc = 1; acc = 0; bad_req = 0; done = 1'b0;
        rd_seen = '0; err_seen = 1'b0;
        m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = addr; m_wd_i = wd;
        s_ready_i = noise;
        while (!done && cyc < 40) begin
            @(posedge clk_i); #1;
            cyc++;
            if (s_req_o != '0) begin
                acc++;
                if (s_req_o !== exp_req) bad_req++;
                if (acc == 1) begin
                    chk({tag, "_s_addr"}, s_addr_o, addr);
                    chk({tag, "_s_we"}, s_we_o, we);
                    chk({tag, "_s_wd"}, s_wd_o, wd);
                    chk({tag, "_s_be"}, s_be_o, be);
                    // Scramble master fields; the latched copies must not follow.
                    m_addr_i = ~addr; m_wd_i = ~wd; m_we_i = ~we;
                end
            end
            if (m_ready_o) begin
                done = 1'b1;
                rd_seen = m_rd_o;
                err_seen = m_err_o;
                chk({tag, "_addr_held"}, s_addr_o, addr);
                m_req_i = 1'b0;
            end
            s_ready_i = noise;
            if (slv >= 0 && ready_at > 0 && acc == ready_at && s_req_o != '0)
                s_ready_i[slv] = 1'b1;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_acc_cycles"}, acc, exp_acc);
        chk({tag, "_bad_req"}, bad_req, 0);
        chk({tag, "_rd"}, rd_seen, exp_rd);
        chk({tag, "_err"}, err_seen, exp_err);
        s_ready_i = '0;
        @(posedge clk_i); #1;
        chk({tag, "_pulse_end"}, m_ready_o, 1'b0);
        chk({tag, "_rd_hold"}, m_rd_o, exp_rd);
        chk({tag, "_idle_req"}, s_req_o, '0);
    endtask

    initial begin
        int pulses;
        rst_i = 1'b1; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = '0;
        m_addr_i = '0; m_wd_i = '0; s_ready_i = '0;
        for (int k = 0; k < N; k++) s_rd_i[k] = 32'hA000_0000 + 32'(k);
        s_rd_i[0] = 32'h1234_5678;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_ready", m_ready_o, 1'b0);
        chk("rst_req", s_req_o, '0);
        chk("rst_rd", m_rd_o, '0);
        chk("rst_err", m_err_o, 1'b0);
        chk("rst_addr", s_addr_o, '0);
        @(posedge clk_i); #1;

        //   tag     we    be     addr           wd            slv rdy noise    exp_req  lat acc exp_rd         err
        txn("rd_s0", 1'b0, 4'hF, 32'h0200_0010, 32'h0,         0,  1, 9'h000, 9'h001, 3,  1, 32'h1234_5678, 1'b0);
        txn("wr_s1", 1'b1, 4'h5, 32'h0300_0000, 32'hCAFE_F00D, 1,  5, 9'h009, 9'h002, 7,  5, 32'h0,         1'b0);
        txn("miss",  1'b0, 4'hF, 32'hFF00_0000, 32'h0,        -1,  0, 9'h1FF, 9'h000, 2,  0, 32'hDEAD_BEEF, 1'b1);
        txn("ovl",   1'b0, 4'hF, 32'h0400_0100, 32'h0,         2,  2, 9'h020, 9'h004, 4,  2, 32'hA000_0002, 1'b0);
        txn("rd_s8", 1'b0, 4'hF, 32'h0A00_0004, 32'h0,         8,  1, 9'h000, 9'h100, 3,  1, 32'hA000_0008, 1'b0);

        // Reset during the second ACCESS cycle.
        m_req_i = 1'b1; m_we_i = 1'b0; m_be_i = 4'hF; m_addr_i = 32'h0200_0020; s_ready_i = '0;
        @(posedge clk_i); #1;
        chk("rst_mid_req_on", s_req_o, 9'h001);
        @(posedge clk_i); #1;
        rst_i = 1'b1; m_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rst_mid_req_off", s_req_o, '0);
        chk("rst_mid_ready", m_ready_o, 1'b0);
        chk("rst_mid_addr", s_addr_o, '0);
        chk("rst_mid_rd", m_rd_o, '0);
        chk("rst_mid_err", m_err_o, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            if (m_ready_o) pulses++;
        end
        chk("rst_mid_no_pulse", pulses, 0);
        txn("post_rst", 1'b0, 4'hF, 32'h0200_0040, 32'h0, 0, 1, 9'h000, 9'h001, 3, 1, 32'h1234_5678, 1'b0);

`ifdef SB_TIMEOUT_EN
        txn("tmo",      1'b0, 4'hF, 32'h0200_0000, 32'h0, 0, 0, 9'h000, 9'h001, 6, 4, 32'hDEAD_BEEF, 1'b1);
        txn("tmo_last", 1'b0, 4'hF, 32'h0200_0000, 32'h0, 0, 4, 9'h000, 9'h001, 6, 4, 32'h1234_5678, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
